// File: rtl/tmds_rx_lane_if.sv
// tmds_rx_lane_if: serial TMDS lane input plus the decoded word bus of one
// receiver lane. The slave modport is the receiver itself; the master
// modport is the side that drives the serial bit and consumes decoded words.
interface tmds_rx_lane_if;
    logic       ser_in;
    logic [7:0] rx_data;
    logic [1:0] rx_c;
    logic       rx_de;
    logic       rx_valid;
    logic       locked;
    logic [7:0] lock_losses;

    modport master (
        output ser_in,
        input  rx_data,
        input  rx_c,
        input  rx_de,
        input  rx_valid,
        input  locked,
        input  lock_losses
    );

    modport slave (
        input  ser_in,
        output rx_data,
        output rx_c,
        output rx_de,
        output rx_valid,
        output locked,
        output lock_losses
    );
endinterface

// File: rtl/tmds_rx_lane.sv
// tmds_rx_lane: single-lane TMDS receiver. Shifts in one bit per clock
// (LSB first), finds 10-bit word alignment from blanking control tokens,
// then decodes each aligned word to a pixel byte or a 2-bit control value.
// Optional feature macro: TMDS_RX_LOSSCNT_EN enables the saturating
// lock_losses counter; without it lock_losses is tied to zero.
module tmds_rx_lane #(
    parameter int LOCK_TOKENS = 8,
    parameter int LOSS_WORDS  = 1024
) (
    input  logic          clk,
    input  logic          reset,
    tmds_rx_lane_if.slave lane
);

    localparam logic [9:0]  TOK_C00       = 10'h354;
    localparam logic [9:0]  TOK_C01       = 10'h0AB;
    localparam logic [9:0]  TOK_C10       = 10'h154;
    localparam logic [9:0]  TOK_C11       = 10'h2AB;
    localparam logic [8:0]  LOCK_TOKENS_C = 9'(LOCK_TOKENS);
    localparam logic [16:0] LOSS_WORDS_C  = 17'(LOSS_WORDS);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    // True when the word is one of the four blanking control tokens.
    function automatic logic is_token(input logic [9:0] q);
        logic hit;
        case (q)
            TOK_C00, TOK_C01, TOK_C10, TOK_C11: hit = 1'b1;
            default:                            hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Control value {C1,C0} carried by a token word.
    function automatic logic [1:0] token_ctl(input logic [9:0] q);
        logic [1:0] c;
        case (q)
            TOK_C00: c = 2'b00;
            TOK_C01: c = 2'b01;
            TOK_C10: c = 2'b10;
            TOK_C11: c = 2'b11;
            default: c = 2'b00;
        endcase
        return c;
    endfunction

    // Undo the optional inversion (q[9]) then the XOR/XNOR chain (q[8]).
    function automatic logic [7:0] decode_data(input logic [9:0] q);
        logic [7:0] dp;
        logic [7:0] d;
        if (q[9]) begin
            dp = ~q[7:0];
        end else begin
            dp = q[7:0];
        end
        d[0] = dp[0];
        for (int i = 1; i < 8; i++) begin
            if (q[8]) begin
                d[i] = dp[i] ^ dp[i-1];
            end else begin
                d[i] = ~(dp[i] ^ dp[i-1]);
            end
        end
        return d;
    endfunction

    state_e      state_q,    state_d;
    logic [9:0]  sr_q;
    logic [3:0]  phase_q,    phase_d;
    logic [7:0]  tok_cnt_q,  tok_cnt_d;
    logic [15:0] loss_cnt_q, loss_cnt_d;
    logic [7:0]  rx_data_q,  rx_data_d;
    logic [1:0]  rx_c_q,     rx_c_d;
    logic        rx_de_q,    rx_de_d;
    logic        rx_valid_q, rx_valid_d;
    logic        locked_q,   locked_d;

    logic        token_s;
    logic        boundary_s;
    logic [8:0]  tok_sum_s;
    logic [16:0] loss_sum_s;

    assign token_s    = is_token(sr_q);
    assign boundary_s = (phase_q == 4'd9);
    assign tok_sum_s  = {1'b0, tok_cnt_q} + 9'd1;
    assign loss_sum_s = {1'b0, loss_cnt_q} + 17'd1;

    // Serial shift register: newest bit enters at the top, oldest sits in sr[0].
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q <= 10'd0;
        end else begin
            sr_q <= {lane.ser_in, sr_q[9:1]};
        end
    end

    // Alignment FSM next state, counters and decoded-word capture.
    always_comb begin
        state_d    = state_q;
        phase_d    = 4'd0;
        tok_cnt_d  = tok_cnt_q;
        loss_cnt_d = loss_cnt_q;
        rx_data_d  = rx_data_q;
        rx_c_d     = rx_c_q;
        rx_de_d    = rx_de_q;
        rx_valid_d = 1'b0;
        locked_d   = locked_q;

        if (boundary_s) begin
            phase_d = 4'd0;
        end else begin
            phase_d = phase_q + 4'd1;
        end

        case (state_q)
            ST_HUNT: begin
                // Any bit offset may be the word start; a token fixes the phase.
                if (token_s) begin
                    state_d   = ST_VERIFY;
                    phase_d   = 4'd0;
                    tok_cnt_d = 8'd1;
                end else begin
                    tok_cnt_d = 8'd0;
                end
            end
            ST_VERIFY: begin
                if (boundary_s && token_s) begin
                    tok_cnt_d = tok_sum_s[7:0];
                    if (tok_sum_s == LOCK_TOKENS_C) begin
                        state_d    = ST_LOCKED;
                        locked_d   = 1'b1;
                        loss_cnt_d = 16'd0;
                    end else begin
                        state_d = ST_VERIFY;
                    end
                end else if (boundary_s) begin
                    state_d   = ST_HUNT;
                    tok_cnt_d = 8'd0;
                end else begin
                    state_d = ST_VERIFY;
                end
            end
            ST_LOCKED: begin
                if (boundary_s && token_s) begin
                    loss_cnt_d = 16'd0;
                    rx_c_d     = token_ctl(sr_q);
                    rx_de_d    = 1'b0;
                    rx_valid_d = 1'b1;
                end else if (boundary_s) begin
                    // The word that exhausts the budget is dropped, not strobed.
                    if (loss_sum_s == LOSS_WORDS_C) begin
                        state_d    = ST_HUNT;
                        locked_d   = 1'b0;
                        loss_cnt_d = 16'd0;
                        tok_cnt_d  = 8'd0;
                    end else begin
                        loss_cnt_d = loss_sum_s[15:0];
                        rx_data_d  = decode_data(sr_q);
                        rx_de_d    = 1'b1;
                        rx_valid_d = 1'b1;
                    end
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d    = ST_HUNT;
                tok_cnt_d  = 8'd0;
                loss_cnt_d = 16'd0;
                locked_d   = 1'b0;
            end
        endcase
    end

    // FSM, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_HUNT;
            phase_q    <= 4'd0;
            tok_cnt_q  <= 8'd0;
            loss_cnt_q <= 16'd0;
            rx_data_q  <= 8'd0;
            rx_c_q     <= 2'd0;
            rx_de_q    <= 1'b0;
            rx_valid_q <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            tok_cnt_q  <= tok_cnt_d;
            loss_cnt_q <= loss_cnt_d;
            rx_data_q  <= rx_data_d;
            rx_c_q     <= rx_c_d;
            rx_de_q    <= rx_de_d;
            rx_valid_q <= rx_valid_d;
            locked_q   <= locked_d;
        end
    end

    assign lane.rx_data  = rx_data_q;
    assign lane.rx_c     = rx_c_q;
    assign lane.rx_de    = rx_de_q;
    assign lane.rx_valid = rx_valid_q;
    assign lane.locked   = locked_q;

`ifdef TMDS_RX_LOSSCNT_EN
    logic [7:0] losses_q, losses_d;
    logic       loss_evt_s;

    assign loss_evt_s = (state_q == ST_LOCKED) && (state_d == ST_HUNT);

    // Saturating count of dropped locks.
    always_comb begin
        losses_d = losses_q;
        if (loss_evt_s && (losses_q != 8'hFF)) begin
            losses_d = losses_q + 8'd1;
        end else begin
            losses_d = losses_q;
        end
    end

    // Lock-loss counter register; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            losses_q <= 8'd0;
        end else begin
            losses_q <= losses_d;
        end
    end

    assign lane.lock_losses = losses_q;
`else
    assign lane.lock_losses = 8'd0;
`endif

endmodule

// File: tb/tb_tmds_rx_lane.sv
// tb_tmds_rx_lane: directed bench for tmds_rx_lane (LOCK_TOKENS=8,
// LOSS_WORDS=16). Serial bits are driven at the falling edge; decoded
// strobes are captured 1 time unit after the rising edge and compared
// against an expected word list built from the source words.
module tb_tmds_rx_lane;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tmds_rx_lane_if lane();

    tmds_rx_lane #(
        .LOCK_TOKENS(8),
        .LOSS_WORDS (16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .lane (lane)
    );

`ifdef TMDS_RX_LOSSCNT_EN
    localparam logic [7:0] LOSSES_AFTER_DROP = 8'd1;
`else
    localparam logic [7:0] LOSSES_AFTER_DROP = 8'd0;
`endif

    int total = 0;
    int bad   = 0;
    int chk   = 0;

    int unsigned cyc = 0;
    logic [10:0] cap_q[$];
    int unsigned cap_t[$];
    logic [10:0] exp_q[$];
    logic [7:0]  last_d = 8'd0;
    logic [1:0]  last_c = 2'd0;

    // Clock cycle counter used to time-stamp strobes.
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe capture: {rx_de, rx_c, rx_data} for every rx_valid cycle.
    always @(posedge clk) begin
        #1;
        if (lane.rx_valid === 1'b1) begin
            cap_q.push_back({lane.rx_de, lane.rx_c, lane.rx_data});
            cap_t.push_back(cyc);
        end
    end

    function automatic logic [9:0] enc(input logic [7:0] d, input logic xnor_m, input logic inv);
        logic [7:0] q;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = xnor_m ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        return {inv, ~xnor_m, inv ? ~q : q};
    endfunction

    function automatic logic is_tok(input logic [9:0] w);
        return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
    endfunction

    task automatic send_bit(input logic b);
        @(negedge clk);
        lane.ser_in = b;
    endtask

    task automatic send_word(input logic [9:0] w);
        for (int i = 0; i < 10; i++) send_bit(w[i]);
    endtask

    task automatic exp_tok(input logic [1:0] c);
        last_c = c;
        exp_q.push_back({1'b0, last_c, last_d});
    endtask

    task automatic exp_dat(input logic [7:0] d);
        last_d = d;
        exp_q.push_back({1'b1, last_c, last_d});
    endtask

    task automatic test_reset();
        reset = 1'b1;
        lane.ser_in = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (lane.rx_data !== 8'd0) begin bad++; $display("FAIL rst_rx_data got=%h want=00", lane.rx_data); end
        total++; if (lane.rx_c !== 2'd0) begin bad++; $display("FAIL rst_rx_c got=%h want=0", lane.rx_c); end
        total++; if (lane.rx_de !== 1'b0) begin bad++; $display("FAIL rst_rx_de got=%b want=0", lane.rx_de); end
        total++; if (lane.rx_valid !== 1'b0) begin bad++; $display("FAIL rst_rx_valid got=%b want=0", lane.rx_valid); end
        total++; if (lane.locked !== 1'b0) begin bad++; $display("FAIL rst_locked got=%b want=0", lane.locked); end
        total++; if (lane.lock_losses !== 8'd0) begin bad++; $display("FAIL rst_lock_losses got=%h want=00", lane.lock_losses); end
        reset = 1'b0;
    endtask

    task automatic test_lock();
        logic [9:0] t;
        t = 10'h354;
        repeat (3) send_bit(1'b1);
        repeat (7) send_word(t);
        total++; if (lane.locked !== 1'b0) begin bad++; $display("FAIL lock_after7 got=%b want=0", lane.locked); end
        send_word(t);
        send_bit(t[0]);
        total++; if (lane.locked !== 1'b0) begin bad++; $display("FAIL lock_at_edge got=%b want=0", lane.locked); end
        send_bit(t[1]);
        total++; if (lane.locked !== 1'b1) begin bad++; $display("FAIL lock_rise got=%b want=1", lane.locked); end
        total++; if (cap_q.size() != 0) begin bad++; $display("FAIL no_strobe_prelock got=%0d want=0", cap_q.size()); end
        for (int i = 2; i < 10; i++) send_bit(t[i]);
        exp_tok(2'b00);
        repeat (7) begin send_word(t); exp_tok(2'b00); end
        send_word(t); exp_tok(2'b00);
        total++; if (cap_q.size() != exp_q.size() - 1) begin bad++; $display("FAIL lock_strobes got=%0d want=%0d", cap_q.size(), exp_q.size() - 1); end
        for (int k = chk; k < cap_q.size() && k < exp_q.size(); k++) begin
            total++; if (cap_q[k] !== exp_q[k]) begin bad++; $display("FAIL lock_word[%0d] got=%h want=%h", k, cap_q[k], exp_q[k]); end
            if (k > 0) begin
                total++; if (cap_t[k] - cap_t[k-1] != 10) begin bad++; $display("FAIL lock_spacing[%0d] got=%0d want=10", k, cap_t[k] - cap_t[k-1]); end
            end
        end
        chk = cap_q.size();
    endtask

    task automatic test_data();
        send_word(10'h100); exp_dat(8'h00);
        send_word(10'h1FF); exp_dat(8'h01);
        send_word(10'h2FF); exp_dat(8'hFE);
        send_word(10'h0AB); exp_tok(2'b01);
        send_word(10'h354); exp_tok(2'b00);
        total++; if (cap_q.size() != exp_q.size() - 1) begin bad++; $display("FAIL data_strobes got=%0d want=%0d", cap_q.size(), exp_q.size() - 1); end
        for (int k = chk; k < cap_q.size() && k < exp_q.size(); k++) begin
            total++; if (cap_q[k] !== exp_q[k]) begin bad++; $display("FAIL data_word[%0d] got=%h want=%h", k, cap_q[k], exp_q[k]); end
            total++; if (cap_t[k] - cap_t[k-1] != 10) begin bad++; $display("FAIL data_spacing[%0d] got=%0d want=10", k, cap_t[k] - cap_t[k-1]); end
        end
        chk = cap_q.size();
    endtask

    task automatic test_frames();
        logic [7:0] p;
        logic [9:0] w;
        for (int ln = 0; ln < 3; ln++) begin
            send_word(10'h154); exp_tok(2'b10);
            send_word(10'h0AB); exp_tok(2'b01);
            for (int x = 0; x < 12; x++) begin
                p = 8'((ln * 37 + x * 11 + 5) & 255);
                w = enc(p, x[0], x[1]);
                if (is_tok(w)) begin
                    p = p ^ 8'h80;
                    w = enc(p, x[0], x[1]);
                end
                send_word(w); exp_dat(p);
            end
        end
        send_word(10'h354); exp_tok(2'b00);
        total++; if (lane.locked !== 1'b1) begin bad++; $display("FAIL frame_locked got=%b want=1", lane.locked); end
        total++; if (cap_q.size() != exp_q.size() - 1) begin bad++; $display("FAIL frame_strobes got=%0d want=%0d", cap_q.size(), exp_q.size() - 1); end
        for (int k = chk; k < cap_q.size() && k < exp_q.size(); k++) begin
            total++; if (cap_q[k] !== exp_q[k]) begin bad++; $display("FAIL frame_word[%0d] got=%h want=%h", k, cap_q[k], exp_q[k]); end
        end
        chk = cap_q.size();
    endtask

    task automatic test_loss();
        for (int i = 0; i < 16; i++) begin
            send_word(10'h100);
            if (i < 15) exp_dat(8'h00);
        end
        send_bit(1'b0);
        total++; if (lane.locked !== 1'b1) begin bad++; $display("FAIL loss_at_edge got=%b want=1", lane.locked); end
        send_bit(1'b0);
        total++; if (lane.locked !== 1'b0) begin bad++; $display("FAIL loss_fall got=%b want=0", lane.locked); end
        repeat (8) send_bit(1'b0);
        total++; if (lane.lock_losses !== LOSSES_AFTER_DROP) begin bad++; $display("FAIL loss_count got=%h want=%h", lane.lock_losses, LOSSES_AFTER_DROP); end
        total++; if (cap_q.size() != exp_q.size()) begin bad++; $display("FAIL loss_strobes got=%0d want=%0d", cap_q.size(), exp_q.size()); end
        for (int k = chk; k < cap_q.size() && k < exp_q.size(); k++) begin
            total++; if (cap_q[k] !== exp_q[k]) begin bad++; $display("FAIL loss_word[%0d] got=%h want=%h", k, cap_q[k], exp_q[k]); end
        end
        chk = cap_q.size();
    endtask

    task automatic test_verify_fail();
        logic [9:0] t;
        t = 10'h354;
        repeat (5) send_word(t);
        send_word(10'h100);
        repeat (7) send_word(t);
        total++; if (lane.locked !== 1'b0) begin bad++; $display("FAIL vfail_after7 got=%b want=0", lane.locked); end
        send_word(t);
        send_bit(t[0]);
        total++; if (lane.locked !== 1'b0) begin bad++; $display("FAIL vfail_at_edge got=%b want=0", lane.locked); end
        send_bit(t[1]);
        total++; if (lane.locked !== 1'b1) begin bad++; $display("FAIL vfail_relock got=%b want=1", lane.locked); end
        total++; if (cap_q.size() != chk) begin bad++; $display("FAIL vfail_no_strobe got=%0d want=%0d", cap_q.size(), chk); end
        for (int i = 2; i < 10; i++) send_bit(t[i]);
        exp_tok(2'b00);
        send_word(10'h1FF); exp_dat(8'h01);
        send_word(10'h2AB); exp_tok(2'b11);
    endtask

    task automatic test_reset_mid();
        logic [9:0] t;
        t = 10'h354;
        for (int i = 0; i < 5; i++) send_bit(t[i]);
        total++; if (cap_q.size() != exp_q.size()) begin bad++; $display("FAIL mid_strobes got=%0d want=%0d", cap_q.size(), exp_q.size()); end
        for (int k = chk; k < cap_q.size() && k < exp_q.size(); k++) begin
            total++; if (cap_q[k] !== exp_q[k]) begin bad++; $display("FAIL mid_word[%0d] got=%h want=%h", k, cap_q[k], exp_q[k]); end
        end
        chk = cap_q.size();
        total++; if (lane.locked !== 1'b1) begin bad++; $display("FAIL mid_pre_locked got=%b want=1", lane.locked); end
        #2 reset = 1'b1;
        #1;
        total++; if (lane.rx_data !== 8'd0) begin bad++; $display("FAIL arst_rx_data got=%h want=00", lane.rx_data); end
        total++; if (lane.rx_c !== 2'd0) begin bad++; $display("FAIL arst_rx_c got=%h want=0", lane.rx_c); end
        total++; if (lane.rx_de !== 1'b0) begin bad++; $display("FAIL arst_rx_de got=%b want=0", lane.rx_de); end
        total++; if (lane.locked !== 1'b0) begin bad++; $display("FAIL arst_locked got=%b want=0", lane.locked); end
        total++; if (lane.lock_losses !== 8'd0) begin bad++; $display("FAIL arst_lock_losses got=%h want=00", lane.lock_losses); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        last_d = 8'd0;
        last_c = 2'd0;
        repeat (7) send_word(t);
        total++; if (lane.locked !== 1'b0) begin bad++; $display("FAIL relock_after7 got=%b want=0", lane.locked); end
        send_word(t);
        send_bit(t[0]);
        total++; if (lane.locked !== 1'b0) begin bad++; $display("FAIL relock_at_edge got=%b want=0", lane.locked); end
        send_bit(t[1]);
        total++; if (lane.locked !== 1'b1) begin bad++; $display("FAIL relock_rise got=%b want=1", lane.locked); end
        for (int i = 2; i < 10; i++) send_bit(t[i]);
        exp_tok(2'b00);
        send_word(10'h0AB); exp_tok(2'b01);
        total++; if (cap_q.size() != exp_q.size() - 1) begin bad++; $display("FAIL relock_strobes got=%0d want=%0d", cap_q.size(), exp_q.size() - 1); end
        for (int k = chk; k < cap_q.size() && k < exp_q.size(); k++) begin
            total++; if (cap_q[k] !== exp_q[k]) begin bad++; $display("FAIL relock_word[%0d] got=%h want=%h", k, cap_q[k], exp_q[k]); end
        end
        chk = cap_q.size();
    endtask

    // Test sequence.
    initial begin
        test_reset();
        test_lock();
        test_data();
        test_frames();
        test_loss();
        test_verify_fail();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tmds_rx_lane.md
# tmds_rx_lane

Single-lane TMDS receiver: the sink-side counterpart of the `display` block's serial DVI outputs (`dvi_r`/`dvi_g`/`dvi_b`). It takes one bit per clock from a serial TMDS lane and finds 10-bit word alignment from the blanking control tokens. It then decodes each word to 8-bit pixel data or a 2-bit control value. Three instances plus a clock-lane checker form the loopback capture path used in simulation and on-board self-test.

## Interface
- `LOCK_TOKENS`, 8: consecutive aligned control tokens required to declare lock (2..255).
- `LOSS_WORDS`, 1024: consecutive locked words without a control token before lock is dropped (16..65535).
- `clk` in 1: bit clock; one serial bit per rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `ser_in` in 1: serial TMDS bit, LSB (q[0]) of each word first.
- `rx_data` out 8: decoded pixel byte; valid when `rx_valid & rx_de`.
- `rx_c` out 2: decoded control value {C1,C0}; valid when `rx_valid & ~rx_de`.
- `rx_de` out 1: 1 = data word, 0 = control token.
- `rx_valid` out 1: one-cycle strobe per decoded word, only while locked.
- `locked` out 1: alignment established.
- `lock_losses` out 8: saturating count of LOCKED→HUNT transitions (see Configuration).

## Operation
- Shift register `sr[9:0]` updates every clock: `sr <= {ser_in, sr[9:1]}`. After 10 shifts, `sr[0]` holds the first-received bit.
- Control tokens as q[9:0]:
  - 0x354 → `rx_c` 00
  - 0x0AB → `rx_c` 01
  - 0x154 → `rx_c` 10
  - 0x2AB → `rx_c` 11
- FSM states:
  - HUNT: compare `sr` against the four tokens every clock. On a match, clear phase counter (0..9), set token count to 1, go to VERIFY.
  - VERIFY: at each word boundary, which is every 10th clock after the aligning edge, a token increments token count. Reaching `LOCK_TOKENS` goes to LOCKED. Any non-token word returns to HUNT and clears the count.
  - LOCKED: decode every boundary word. A token clears the loss counter; a data word increments it. Reaching `LOSS_WORDS` goes to HUNT and increments `lock_losses`.
- Data decode:
  - d' = q[9] ? ~q[7:0] : q[7:0].
  - d[0] = d'[0].
  - For i=1..7: d[i] = d'[i]^d'[i-1] if q[8]=1, else ~(d'[i]^d'[i-1]).
- A token word always yields `rx_de`=0 with `rx_c` per the table, even inside active video; no disparity check is performed.
- Phase stays fixed once locked; the receiver never re-slips bits without passing through HUNT.

## Timing
- Reset values:
  - `rx_data`=0, `rx_c`=0, `rx_de`=0, `rx_valid`=0, `locked`=0, `lock_losses`=0.
  - `sr`=0, state HUNT, all counters 0.
- Latency: a word fully present in `sr` after edge k appears on the `rx_*` outputs after edge k+1, with `rx_valid`=1 for exactly that cycle.
- `rx_data`/`rx_c`/`rx_de` hold until the next strobe.
- `locked` rises at the edge following the `LOCK_TOKENS`-th aligned token.
- The first `rx_valid` is for the next boundary word after lock. No strobes are issued in HUNT or VERIFY.
- `locked` falls at the edge following the `LOSS_WORDS`-th tokenless word; no strobe is issued for that word.
- In HUNT, a match on the same cycle that the FSM enters HUNT from LOCKED or VERIFY is ignored. Hunting starts the following clock.
- Reset asserted mid-word or mid-lock returns all outputs to reset values immediately, without waiting for a clock. Deassertion resumes in HUNT.

## Configuration
- `TMDS_RX_LOSSCNT_EN` defined: `lock_losses` is an 8-bit counter saturating at 255 and cleared only by `reset`.
- Not defined: the port remains and is tied to 0; no counter logic is synthesized.

## Test plan
- Reset with `ser_in`=1, then feed 8×0x354 at arbitrary bit offset → `locked`=1 after the 8th token; 8 further 0x354 give 8 strobes with `rx_de`=0, `rx_c`=00.
- After lock, send 0x100, 0x1FF, 0x2FF, then 0x0AB → `rx_data` 0x00, 0x01, 0xFE with `rx_de`=1, then `rx_de`=0 with `rx_c`=01. Strobes are spaced exactly 10 clocks apart.
- In VERIFY after 5 tokens, inject one 0x100 → back to HUNT, `locked` stays 0. 8 new tokens then achieve lock.
- `LOSS_WORDS`=16: after lock, send 16 data words 0x100 → 15 strobes, `locked` falls, `lock_losses`=1 (0 without the macro).
- Simulate full 800×525 frames (640 data words per line) → `locked` stays 1 and the decoded stream matches source pixels.
- Assert `reset` for 3 clocks while locked mid-word → all outputs go to 0 asynchronously; after release, relock requires 8 tokens.
